// File: rtl/disp_axi_rd_arb.sv
// disp_axi_rd_arb: two-port AXI read-channel arbiter, one burst in flight.
// Port 0 is the display controller, port 1 the secondary reader.
//
// Ports:
//   ACLK, ARESETN            clock, async active-low reset
//   S0_* / S1_*              requester AR and R channels (ARADDR, ARVALID,
//                            ARREADY, RDATA, RVALID, RLAST, RREADY)
//   M_*                      shared downstream AR and R channels
//   GRANT                    one-hot channel owner, 2'b00 when idle
//
// Build option:
//   DISP_ARB_RR_EN  defined   -> round-robin on simultaneous requests
//                   undefined -> fixed priority, port 0 wins ties
module disp_axi_rd_arb #(
    parameter int DW = 64
) (
    input  logic          ACLK,
    input  logic          ARESETN,

    input  logic [31:0]   S0_ARADDR,
    input  logic          S0_ARVALID,
    output logic          S0_ARREADY,
    output logic [DW-1:0] S0_RDATA,
    output logic          S0_RVALID,
    output logic          S0_RLAST,
    input  logic          S0_RREADY,

    input  logic [31:0]   S1_ARADDR,
    input  logic          S1_ARVALID,
    output logic          S1_ARREADY,
    output logic [DW-1:0] S1_RDATA,
    output logic          S1_RVALID,
    output logic          S1_RLAST,
    input  logic          S1_RREADY,

    output logic [31:0]   M_ARADDR,
    output logic          M_ARVALID,
    input  logic          M_ARREADY,
    input  logic [DW-1:0] M_RDATA,
    input  logic          M_RVALID,
    input  logic          M_RLAST,
    output logic          M_RREADY,

    output logic [1:0]    GRANT
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [1:0] grant_q;
    logic [1:0] grant_nxt;
    logic [1:0] win;
    logic       in_addr;
    logic       in_data;
    logic       m_rready;

`ifdef DISP_ARB_RR_EN
    // 1'b1 means port 1 was served last, so port 0 wins the next tie.
    logic last_q;
    logic last_nxt;
`endif

    // Winner of the current request set; 2'b00 when nobody asks.
    always_comb begin
        win = 2'b00;
        if (S0_ARVALID && S1_ARVALID) begin
`ifdef DISP_ARB_RR_EN
            win = last_q ? 2'b01 : 2'b10;
`else
            win = 2'b01;
`endif
        end else if (S0_ARVALID) begin
            win = 2'b01;
        end else if (S1_ARVALID) begin
            win = 2'b10;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state   <= IDLE;
            grant_q <= 2'b00;
`ifdef DISP_ARB_RR_EN
            last_q  <= 1'b1;
`endif
        end else begin
            state   <= state_nxt;
            grant_q <= grant_nxt;
`ifdef DISP_ARB_RR_EN
            last_q  <= last_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        grant_nxt = grant_q;
`ifdef DISP_ARB_RR_EN
        last_nxt  = last_q;
`endif
        unique case (state)
            IDLE: begin
                if (win != 2'b00) begin
                    state_nxt = ADDR;
                    grant_nxt = win;
`ifdef DISP_ARB_RR_EN
                    last_nxt  = win[1];
`endif
                end
            end
            ADDR: begin
                // M_ARVALID is held high for the whole state.
                if (M_ARREADY) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (M_RVALID && m_rready && M_RLAST) begin
                    state_nxt = IDLE;
                    grant_nxt = 2'b00;
                end
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = 2'b00;
            end
        endcase
    end

    assign in_addr = (state == ADDR);
    assign in_data = (state == DATA);

    assign m_rready = in_data &&
                      ((grant_q[0] && S0_RREADY) ||
                       (grant_q[1] && S1_RREADY));

    // Everything is gated by state and grant, so the idle port and
    // the idle phases always see zeros.
    always_comb begin
        M_ARVALID  = in_addr;
        M_ARADDR   = 32'h0;
        M_RREADY   = m_rready;
        S0_ARREADY = 1'b0;
        S1_ARREADY = 1'b0;
        S0_RVALID  = 1'b0;
        S1_RVALID  = 1'b0;
        S0_RLAST   = 1'b0;
        S1_RLAST   = 1'b0;
        S0_RDATA   = '0;
        S1_RDATA   = '0;
        if (in_addr) begin
            M_ARADDR   = grant_q[1] ? S1_ARADDR : S0_ARADDR;
            S0_ARREADY = grant_q[0] && M_ARREADY;
            S1_ARREADY = grant_q[1] && M_ARREADY;
        end
        if (in_data && grant_q[0]) begin
            S0_RVALID = M_RVALID;
            S0_RLAST  = M_RLAST;
            S0_RDATA  = M_RDATA;
        end
        if (in_data && grant_q[1]) begin
            S1_RVALID = M_RVALID;
            S1_RLAST  = M_RLAST;
            S1_RDATA  = M_RDATA;
        end
    end

    assign GRANT = grant_q;

endmodule

// File: tb/tb_disp_axi_rd_arb.sv
// Directed bench for disp_axi_rd_arb.
// Works with and without DISP_ARB_RR_EN defined.
module tb_disp_axi_rd_arb;

    localparam int DW = 64;

    logic          ACLK = 1'b0;
    logic          ARESETN;
    logic [31:0]   S0_ARADDR, S1_ARADDR;
    logic          S0_ARVALID, S1_ARVALID;
    logic          S0_ARREADY, S1_ARREADY;
    logic [DW-1:0] S0_RDATA, S1_RDATA;
    logic          S0_RVALID, S1_RVALID;
    logic          S0_RLAST, S1_RLAST;
    logic          S0_RREADY, S1_RREADY;
    logic [31:0]   M_ARADDR;
    logic          M_ARVALID, M_ARREADY;
    logic [DW-1:0] M_RDATA;
    logic          M_RVALID, M_RLAST, M_RREADY;
    logic [1:0]    GRANT;

    int checks = 0;
    int errors = 0;

    always #5 ACLK = ~ACLK;

    disp_axi_rd_arb #(.DW(DW)) dut (
        .ACLK       (ACLK),
        .ARESETN    (ARESETN),
        .S0_ARADDR  (S0_ARADDR),
        .S0_ARVALID (S0_ARVALID),
        .S0_ARREADY (S0_ARREADY),
        .S0_RDATA   (S0_RDATA),
        .S0_RVALID  (S0_RVALID),
        .S0_RLAST   (S0_RLAST),
        .S0_RREADY  (S0_RREADY),
        .S1_ARADDR  (S1_ARADDR),
        .S1_ARVALID (S1_ARVALID),
        .S1_ARREADY (S1_ARREADY),
        .S1_RDATA   (S1_RDATA),
        .S1_RVALID  (S1_RVALID),
        .S1_RLAST   (S1_RLAST),
        .S1_RREADY  (S1_RREADY),
        .M_ARADDR   (M_ARADDR),
        .M_ARVALID  (M_ARVALID),
        .M_ARREADY  (M_ARREADY),
        .M_RDATA    (M_RDATA),
        .M_RVALID   (M_RVALID),
        .M_RLAST    (M_RLAST),
        .M_RREADY   (M_RREADY),
        .GRANT      (GRANT)
    );

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctl"},
            {54'b0, GRANT, M_ARVALID, M_RREADY,
             S0_ARREADY, S1_ARREADY, S0_RVALID, S1_RVALID,
             S0_RLAST, S1_RLAST}, 64'h0);
        chk({tag, "_dat"},
            S0_RDATA | S1_RDATA | {32'b0, M_ARADDR}, 64'h0);
    endtask

    task automatic idle_inputs();
        S0_ARADDR  = 32'h0;
        S1_ARADDR  = 32'h0;
        S0_ARVALID = 1'b0;
        S1_ARVALID = 1'b0;
        S0_RREADY  = 1'b0;
        S1_RREADY  = 1'b0;
        M_ARREADY  = 1'b0;
        M_RDATA    = '0;
        M_RVALID   = 1'b0;
        M_RLAST    = 1'b0;
    endtask

    logic [63:0] src [4];
    logic [63:0] recv [8];
    logic [1:0]  exp_g [3];
    int          k;
    int          nrecv;

    initial begin
        idle_inputs();
        ARESETN = 1'b0;
        #12;
        // Requests during reset must not be granted.
        S0_ARVALID = 1'b1;
        M_RVALID   = 1'b1;
        settle();
        chk_all_zero("reset");
        tick();
        chk_all_zero("reset_edge");
        idle_inputs();
        ARESETN = 1'b1;
        tick();

        // Single request, address pass-through one cycle later.
        S0_ARADDR  = 32'h0000_1000;
        S0_ARVALID = 1'b1;
        M_ARREADY  = 1'b1;
        settle();
        chk("idle_arvalid", M_ARVALID, 0);
        chk("idle_araddr", M_ARADDR, 0);
        tick();
        chk("a_grant", GRANT, 2'b01);
        chk("a_arvalid", M_ARVALID, 1);
        chk("a_araddr", M_ARADDR, 32'h0000_1000);
        chk("a_s0_arready", S0_ARREADY, 1);
        chk("a_s1_arready", S1_ARREADY, 0);
        S0_ARVALID = 1'b0;
        tick();
        chk("d_arvalid", M_ARVALID, 0);
        chk("d_grant", GRANT, 2'b01);

        // 16-beat burst to port 0.
        S0_RREADY = 1'b1;
        for (int i = 0; i < 16; i++) begin
            M_RVALID = 1'b1;
            M_RDATA  = 64'hD000 + 64'(i);
            M_RLAST  = (i == 15);
            settle();
            chk("b_s0_rvalid", S0_RVALID, 1);
            chk("b_s0_rdata", S0_RDATA, 64'hD000 + 64'(i));
            chk("b_s0_rlast", S0_RLAST, (i == 15));
            chk("b_s1_rvalid", S1_RVALID, 0);
            chk("b_m_rready", M_RREADY, 1);
            tick();
        end
        chk("b_grant_end", GRANT, 2'b00);
        // Stray beat in IDLE is ignored.
        settle();
        chk("stray_rready", M_RREADY, 0);
        chk("stray_s0_rvalid", S0_RVALID, 0);
        M_RVALID = 1'b0;
        M_RLAST  = 1'b0;

        // Address stall for 5 cycles, requester drops ARVALID.
        S0_ARADDR  = 32'h0000_2000;
        S0_ARVALID = 1'b1;
        M_ARREADY  = 1'b0;
        tick();
        S0_ARVALID = 1'b0;
        for (int i = 0; i < 5; i++) begin
            settle();
            chk("stall_arvalid", M_ARVALID, 1);
            chk("stall_araddr", M_ARADDR, 32'h0000_2000);
            chk("stall_s0_arready", S0_ARREADY, 0);
            tick();
        end
        M_ARREADY = 1'b1;
        settle();
        chk("stall_s0_arready_go", S0_ARREADY, 1);
        tick();
        M_ARREADY = 1'b0;

        // 4-beat burst with S0_RREADY low for 3 cycles.
        src[0] = 64'hE0;
        src[1] = 64'hE1;
        src[2] = 64'hE2;
        src[3] = 64'hE3;
        k      = 0;
        nrecv  = 0;
        for (int c = 0; c < 20 && k < 4; c++) begin
            M_RVALID  = 1'b1;
            M_RDATA   = src[k];
            M_RLAST   = (k == 3);
            S0_RREADY = !(c >= 1 && c <= 3);
            settle();
            chk("bp_m_rready", M_RREADY, S0_RREADY);
            if (S0_RVALID && S0_RREADY && nrecv < 8) begin
                recv[nrecv] = S0_RDATA;
                nrecv++;
            end
            if (M_RVALID && M_RREADY) k++;
            tick();
        end
        M_RVALID  = 1'b0;
        M_RLAST   = 1'b0;
        S0_RREADY = 1'b1;
        chk("bp_beats", nrecv, 4);
        for (int j = 0; j < 4; j++) begin
            chk("bp_data", (j < nrecv) ? recv[j] : 64'hX, src[j]);
        end
        chk("bp_grant_end", GRANT, 2'b00);

        // Fresh reset, then both ports request continuously.
        ARESETN = 1'b0;
        settle();
        chk_all_zero("reset2");
        tick();
        ARESETN = 1'b1;
`ifdef DISP_ARB_RR_EN
        exp_g[0] = 2'b01;
        exp_g[1] = 2'b10;
        exp_g[2] = 2'b01;
`else
        exp_g[0] = 2'b01;
        exp_g[1] = 2'b01;
        exp_g[2] = 2'b01;
`endif
        S0_ARADDR  = 32'h0000_3000;
        S1_ARADDR  = 32'h0000_4000;
        S0_ARVALID = 1'b1;
        S1_ARVALID = 1'b1;
        M_ARREADY  = 1'b1;
        M_RVALID   = 1'b1;
        M_RLAST    = 1'b1;
        M_RDATA    = 64'h77;
        S0_RREADY  = 1'b1;
        S1_RREADY  = 1'b1;
        for (int b = 0; b < 3; b++) begin
            tick();
            chk("rr_grant_addr", GRANT, exp_g[b]);
            chk("rr_araddr", M_ARADDR,
                (exp_g[b] == 2'b01) ? 32'h3000 : 32'h4000);
            tick();
            chk("rr_grant_data", GRANT, exp_g[b]);
            tick();
            chk("rr_idle_gap", GRANT, 2'b00);
        end
        idle_inputs();

        // Reset on beat 8 of 16, then a port 1 request.
        S0_ARADDR  = 32'h0000_6000;
        S0_ARVALID = 1'b1;
        M_ARREADY  = 1'b1;
        tick();
        S0_ARVALID = 1'b0;
        tick();
        S0_RREADY = 1'b1;
        for (int i = 0; i < 7; i++) begin
            M_RVALID = 1'b1;
            M_RDATA  = 64'hF000 + 64'(i);
            tick();
        end
        M_RDATA = 64'hF007;
        settle();
        chk("rst_b8_s0_rvalid", S0_RVALID, 1);
        ARESETN = 1'b0;
        #1;
        chk_all_zero("rst_mid");
        tick();
        ARESETN  = 1'b1;
        M_RVALID = 1'b0;
        S1_ARADDR  = 32'h0000_5000;
        S1_ARVALID = 1'b1;
        settle();
        chk("post_rst_grant", GRANT, 2'b00);
        tick();
        chk("s1_grant", GRANT, 2'b10);
        chk("s1_araddr", M_ARADDR, 32'h0000_5000);
        chk("s1_arready", S1_ARREADY, 1);
        chk("s1_s0_arready", S0_ARREADY, 0);
        S1_ARVALID = 1'b0;
        tick();
        M_RVALID  = 1'b1;
        M_RLAST   = 1'b1;
        M_RDATA   = 64'hBEEF;
        S1_RREADY = 1'b1;
        settle();
        chk("s1_rdata", S1_RDATA, 64'hBEEF);
        chk("s1_rlast", S1_RLAST, 1);
        chk("s1_s0_rvalid", S0_RVALID, 0);
        chk("s1_s0_rdata", S0_RDATA, 0);
        tick();
        chk("s1_grant_end", GRANT, 2'b00);
        idle_inputs();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/disp_axi_rd_arb.md
DISP_AXI_RD_ARB -- requirements
Module: disp_axi_rd_arb

Interface
REQ-001 Parameter DW, default 64: R-channel data width in bits for all ports.
REQ-002 ACLK  input  1  single clock; all state changes on its rising edge.
REQ-003 ARESETN  input  1  asynchronous, active-low reset.
REQ-004 Sn_ARADDR  input  32  requester n read address (n=0,1; port 0 = display controller, port 1 = secondary reader).
REQ-005 Sn_ARVALID  input  1  requester n address request.
REQ-006 Sn_ARREADY  output  1  address accepted for requester n.
REQ-007 Sn_RDATA  output  DW  read data routed to requester n.
REQ-008 Sn_RVALID  output  1  read beat valid to requester n.
REQ-009 Sn_RLAST  output  1  last beat to requester n.
REQ-010 Sn_RREADY  input  1  requester n accepts beat.
REQ-011 M_ARADDR  output  32  shared AXI read address.
REQ-012 M_ARVALID  output  1  shared address valid.
REQ-013 M_ARREADY  input  1  slave accepts address.
REQ-014 M_RDATA  input  DW  shared read data.
REQ-015 M_RVALID  input  1  shared beat valid.
REQ-016 M_RLAST  input  1  shared last beat.
REQ-017 M_RREADY  output  1  shared beat ready.
REQ-018 GRANT  output  2  one-hot owner of the read channel (bit n = port n), 2'b00 when idle.

Function
REQ-019 The block SHALL implement states IDLE, ADDR, DATA, with exactly one outstanding burst at any time.
REQ-020 IDLE: if S0_ARVALID or S1_ARVALID is high at a rising edge, the block SHALL register the winner into GRANT and enter ADDR; otherwise it SHALL remain in IDLE.
REQ-021 Arbitration with a single requester SHALL grant that requester; with both requesting, the winner SHALL follow REQ-033/REQ-034.
REQ-022 ADDR: M_ARVALID SHALL be 1 and M_ARADDR SHALL equal the granted port's Sn_ARADDR (combinational pass-through).
REQ-023 ADDR: granted Sn_ARREADY SHALL equal M_ARREADY; on M_ARVALID&M_ARREADY the block SHALL enter DATA.
REQ-024 DATA: M_RREADY SHALL equal granted Sn_RREADY; granted Sn_RVALID/Sn_RLAST/Sn_RDATA SHALL equal M_RVALID/M_RLAST/M_RDATA.
REQ-025 DATA: on M_RVALID&M_RREADY&M_RLAST the block SHALL return to IDLE and clear GRANT to 2'b00 at that edge.
REQ-026 Outside the owning state, M_ARVALID, M_RREADY, every Sn_ARREADY and every Sn_RVALID/Sn_RLAST SHALL be 0; the non-granted port SHALL see all 0 at all times; M_ARADDR SHALL be 0 in IDLE.
REQ-027 Latency: a request sampled in IDLE at edge N SHALL produce M_ARVALID=1 in the cycle after edge N; one idle cycle SHALL separate consecutive bursts.
REQ-028 M_RVALID while not in DATA SHALL be ignored (M_RREADY=0, no routing).
REQ-029 A requester deasserting ARVALID during ADDR SHALL NOT cancel the grant; M_ARVALID SHALL stay 1 until M_ARREADY.
REQ-030 A requester requesting in the same cycle its burst completes SHALL be considered only in the following IDLE cycle.

Reset
REQ-031 ARESETN low SHALL immediately (asynchronously) force IDLE, GRANT=2'b00, the last-served pointer to port 1, and all outputs to 0.
REQ-032 Reset asserted mid-burst SHALL abandon the burst; after release the block SHALL start in IDLE with no memory of the abandoned transfer.

Configuration
REQ-033 With DISP_ARB_RR_EN defined, on simultaneous requests the block SHALL grant the port other than the last-served port, updating the last-served pointer at each grant.
REQ-034 Without DISP_ARB_RR_EN, port 0 SHALL always win simultaneous requests and no last-served pointer SHALL exist.

Verification
REQ-035 Reset, then S0_ARVALID=1, S0_ARADDR=0x00001000, M_ARREADY=1 -> M_ARVALID=1 with M_ARADDR=0x00001000 one cycle later, GRANT=2'b01.
REQ-036 Port 0 burst of 16 beats, S0_RREADY=1 -> 16 beats routed to S0, S1_RVALID=0 throughout, GRANT=2'b00 after the RLAST beat.
REQ-037 Both ports request continuously, 3 bursts, DISP_ARB_RR_EN defined -> grant order 0,1,0; without the macro -> 0,0,0.
REQ-038 M_ARREADY held 0 for 5 cycles in ADDR -> M_ARVALID and M_ARADDR stable all 5 cycles, S0_ARREADY=0 until M_ARREADY=1.
REQ-039 ARESETN pulled low on beat 8 of 16 -> all outputs 0 in the same cycle; after release a new S1 request is granted normally.
REQ-040 S0_RREADY=0 for 3 cycles mid-burst -> M_RREADY=0 those cycles, no beat lost or duplicated.
